// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and default timeout for the memory-port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {MEM_ARB_IDLE, MEM_ARB_BUSY, MEM_ARB_KILL} type_mem_arb_states_e;
    localparam int MEM_ARB_TIMEOUT_CYC = 47;
endpackage

// File: rtl/rr_grant_sel.sv
// rr_grant_sel: picks the first active request at or after ptr, wrapping modulo NUM_REQ
module rr_grant_sel #(
    parameter int NUM_REQ = 3,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               any
);
    logic [IW-1:0] k;
    // Scan from the far end back toward ptr so the closest request wins.
    always_comb begin
        idx = '0;
        k = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % NUM_REQ);
            if (req[k]) idx = k;
        end
    end
    assign any = |req;
    assign gnt = any ? NUM_REQ'(1) << idx : '0;
endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin owner of the single memory port, one outstanding
// transaction, with per-owner kill and a forced-abort timeout.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = MEM_ARB_TIMEOUT_CYC,
    parameter int TO_W        = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        kill_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] w_data_i,
    input  logic [NUM_REQ-1:0]        w_en_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [DATA_W-1:0]         r_data_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      timeout_o,
    output logic                      mem_req_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_w_data_o,
    output logic                      mem_w_en_o,
    input  logic                      mem_ack_i,
    input  logic [DATA_W-1:0]         mem_r_data_i
);
    localparam int IW = $clog2(NUM_REQ);

    type_mem_arb_states_e state;
    logic [IW-1:0]      rr_ptr, owner, sel_idx, nxt_ptr;
    logic [NUM_REQ-1:0] sel_gnt;
    logic [TO_W-1:0]    cnt;
    logic               sel_any, kill_own, to_hit, active, done;

    rr_grant_sel #(.NUM_REQ(NUM_REQ), .IW(IW)) u_sel (
        .req(req_i),
        .ptr(rr_ptr),
        .gnt(sel_gnt),
        .idx(sel_idx),
        .any(sel_any)
    );

    assign active    = state != MEM_ARB_IDLE;
    assign kill_own  = |(kill_i & grant_o);
    assign to_hit    = cnt == TO_W'(TIMEOUT_CYC);
    // A memory ack in the abort cycle takes priority over the timeout.
    assign done      = active && (mem_ack_i || to_hit);
    assign nxt_ptr   = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign ack_o     = (state == MEM_ARB_BUSY && mem_ack_i && !kill_own) ? grant_o : '0;
    assign r_data_o  = |ack_o ? mem_r_data_i : '0;
    assign timeout_o = active && to_hit && !mem_ack_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= MEM_ARB_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            cnt          <= '0;
            grant_o      <= '0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            mem_w_data_o <= '0;
            mem_w_en_o   <= 1'b0;
        end else if (!active) begin
            if (sel_any) begin
                state        <= MEM_ARB_BUSY;
                owner        <= sel_idx;
                grant_o      <= sel_gnt;
                cnt          <= '0;
                mem_req_o    <= 1'b1;
                mem_addr_o   <= addr_i[sel_idx*ADDR_W +: ADDR_W];
                mem_w_data_o <= w_data_i[sel_idx*DATA_W +: DATA_W];
                mem_w_en_o   <= w_en_i[sel_idx];
            end
        end else if (done) begin
            state     <= MEM_ARB_IDLE;
            grant_o   <= '0;
            mem_req_o <= 1'b0;
            rr_ptr    <= nxt_ptr;
        end else begin
            cnt <= cnt + 1'b1;
            if (kill_own) state <= MEM_ARB_KILL;
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: scenario tasks with inline checks plus an ack scoreboard
module tb_mem_rr_arbiter;
    localparam int N = 3, AW = 32, DW = 128;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] req = '0, kill = '0, w_en = '0, ack, grant;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] w_data = '0;
    logic [DW-1:0] r_data, mem_w_data, mem_r_data = '0;
    logic [AW-1:0] mem_addr;
    logic timeout, mem_req, mem_w_en, mem_ack = 1'b0;
    int checks = 0, failures = 0;

    typedef struct {int idx; logic [DW-1:0] data;} exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_rr_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .kill_i(kill), .addr_i(addr),
        .w_data_i(w_data), .w_en_i(w_en), .ack_o(ack), .r_data_o(r_data),
        .grant_o(grant), .timeout_o(timeout), .mem_req_o(mem_req),
        .mem_addr_o(mem_addr), .mem_w_data_o(mem_w_data), .mem_w_en_o(mem_w_en),
        .mem_ack_i(mem_ack), .mem_r_data_i(mem_r_data)
    );

    // Scoreboard: every ack pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (ack !== '0) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_ack got=%b want=none", ack);
            end else begin
                e = exp_q.pop_front();
                if (ack !== (3'b001 << e.idx) || r_data !== e.data) begin
                    failures++;
                    $display("FAIL sb_ack got=%b/%h want=%b/%h", ack, r_data, 3'b001 << e.idx, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=hang want=finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_grant(input logic [N-1:0] want, input string name);
        int n = 0;
        do begin
            cyc();
            smp();
            n++;
        end while (!mem_req && n < 8);
        checks++;
        if (grant !== want || !mem_req) begin
            failures++;
            $display("FAIL %s got=%b req=%b want=%b", name, grant, mem_req, want);
        end
    endtask

    task automatic do_ack(input int idx, input logic [DW-1:0] d);
        cyc();
        mem_ack = 1'b1;
        mem_r_data = d;
        exp_q.push_back('{idx, d});
        smp();
        checks++;
        if (ack !== (3'b001 << idx)) begin
            failures++;
            $display("FAIL ack_owner got=%b want=%b", ack, 3'b001 << idx);
        end
        cyc();
        mem_ack = 1'b0;
        mem_r_data = '0;
    endtask

    task automatic test_reset();
        smp();
        checks++;
        if ({mem_req, mem_w_en, grant, ack, timeout} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0", {mem_req, mem_w_en, grant, ack, timeout});
        end
        checks++;
        if (mem_addr !== '0 || mem_w_data !== '0 || r_data !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h want=0", mem_addr, mem_w_data, r_data);
        end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        logic bad = 1'b0;
        cyc();
        req = 3'b010;
        addr[AW +: AW] = 32'h8000_0040;
        smp();
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL read_cycle0 got=%b want=0", mem_req);
        end
        wait_grant(3'b010, "read_grant");
        checks++;
        if (mem_addr !== 32'h8000_0040 || mem_w_en !== 1'b0) begin
            failures++;
            $display("FAIL read_cmd got=%h/%b want=80000040/0", mem_addr, mem_w_en);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            kill = (i == 1) ? 3'b001 : 3'b000;
            smp();
            if (ack !== '0 || !mem_req) bad = 1'b1;
        end
        kill = '0;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL read_wait got=early_ack_or_drop want=held");
        end
        do_ack(1, {16{8'hA5}});
        req = '0;
        smp();
        checks++;
        if (mem_req !== 1'b0 || grant !== '0) begin
            failures++;
            $display("FAIL read_idle got=%b/%b want=0/000", mem_req, grant);
        end
        req = 3'b111;
        wait_grant(3'b100, "rr_ptr_after_read");
        do_ack(2, {4{$urandom}});
        req = '0;
    endtask

    task automatic test_round_robin();
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_grant(3'b001 << (i % 3), "rr_rotate");
            do_ack(i % 3, {4{$urandom}});
        end
        req = '0;
    endtask

    task automatic test_kill();
        req = 3'b010;
        wait_grant(3'b010, "kill_grant");
        cyc();
        cyc();
        kill = 3'b010;
        smp();
        checks++;
        if (ack !== '0 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL kill_cycle3 got=%b/%b want=000/1", ack, mem_req);
        end
        cyc();
        kill = '0;
        req = '0;
        smp();
        checks++;
        if (mem_req !== 1'b1 || grant !== 3'b010) begin
            failures++;
            $display("FAIL kill_hold got=%b/%b want=1/010", mem_req, grant);
        end
        cyc();
        cyc();
        mem_ack = 1'b1;
        mem_r_data = {4{32'hDEAD_0001}};
        smp();
        checks++;
        if (ack !== '0) begin
            failures++;
            $display("FAIL kill_no_ack got=%b want=000", ack);
        end
        cyc();
        mem_ack = 1'b0;
        smp();
        checks++;
        if (mem_req !== 1'b0 || grant !== '0) begin
            failures++;
            $display("FAIL kill_idle got=%b/%b want=0/000", mem_req, grant);
        end
    endtask

    task automatic test_timeout();
        logic bad = 1'b0;
        req = 3'b100;
        wait_grant(3'b100, "to_grant");
        for (int i = 1; i <= 46; i++) begin
            cyc();
            if (i == 1) req = '0;
            smp();
            if (timeout || !mem_req) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL to_early got=abort_before_47 want=busy");
        end
        cyc();
        smp();
        checks++;
        if (timeout !== 1'b1 || ack !== '0) begin
            failures++;
            $display("FAIL to_pulse got=%b/%b want=1/000", timeout, ack);
        end
        cyc();
        smp();
        checks++;
        if (timeout !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL to_after got=%b/%b want=0/0", timeout, mem_req);
        end
        cyc();
        mem_ack = 1'b1;
        smp();
        checks++;
        if (ack !== '0 || mem_req !== 1'b0 || grant !== '0) begin
            failures++;
            $display("FAIL late_ack got=%b/%b/%b want=000/0/000", ack, mem_req, grant);
        end
        cyc();
        mem_ack = 1'b0;
    endtask

    task automatic test_write();
        req = 3'b001;
        w_en = 3'b001;
        w_data[0 +: DW] = {8{16'h1234}};
        addr[0 +: AW] = 32'h0000_1000;
        wait_grant(3'b001, "write_grant");
        checks++;
        if (mem_w_en !== 1'b1 || mem_w_data !== {8{16'h1234}} || mem_addr !== 32'h0000_1000) begin
            failures++;
            $display("FAIL write_cmd got=%b/%h/%h want=1/1234../1000", mem_w_en, mem_w_data, mem_addr);
        end
        cyc();
        addr[0 +: AW] = 32'hDEAD_BEEF;
        w_data[0 +: DW] = '0;
        w_en = '0;
        kill = 3'b010;
        smp();
        checks++;
        if (mem_w_en !== 1'b1 || mem_w_data !== {8{16'h1234}} || mem_addr !== 32'h0000_1000) begin
            failures++;
            $display("FAIL write_stable got=%b/%h/%h want=1/1234../1000", mem_w_en, mem_w_data, mem_addr);
        end
        kill = '0;
        do_ack(0, {4{32'h0BAD_F00D}});
        req = '0;
    endtask

    task automatic test_async_reset();
        req = 3'b010;
        wait_grant(3'b010, "arst_grant");
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || grant !== '0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL async_reset got=%b/%b/%h want=0/000/0", mem_req, grant, mem_addr);
        end
        cyc();
        rst_n = 1'b1;
        req = 3'b111;
        wait_grant(3'b001, "first_after_reset");
        do_ack(0, {4{$urandom}});
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_kill();
        test_timeout();
        test_write();
        test_async_reset();
        cyc();
        smp();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
